// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// Imported by the bridge and its wait-state timer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    localparam int DEF_DATAWIDTH    = 32;
    localparam int DEF_ADDRESSWIDTH = 8;

    localparam logic OKAY = 1'b0;
    localparam logic ERR  = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready.
// Flags the last permitted wait cycle so the bridge can abort.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] LAST = LASTI[W-1:0];

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT disables the abort entirely.
    assign expired_o = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 master bridge.
// Registered APB outputs, one-cycle response strobe, wait timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATAWIDTH-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDRESSWIDTH-1:0] paddr,
    output logic [DATAWIDTH-1:0]    pwdata,
    input  logic [DATAWIDTH-1:0]    prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    state_e                  state_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDRESSWIDTH-1:0] paddr_q;
    logic [DATAWIDTH-1:0]    pwdata_q;
    logic                    rsp_valid_q;
    logic [DATAWIDTH-1:0]    rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    expired;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q == IDLE) && cmd_valid),
        .en_i     ((state_q == ACCESS) && !pready),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= OKAY;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr ? ERR : OKAY;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        state_q     <= IDLE;
                    end else if (expired) begin
                        // Stuck slave: give up and report an error.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of apb_slave: converts a simple valid/ready command interface (from a CPU-side or test sequencer) into APB3 SETUP/ACCESS transfers.
- Returns read data and error status on a one-cycle response strobe.
- Adds a bounded wait-state timeout, so a stuck slave cannot hang the command source.
- One APB slave per instance; psel is a single bit.

Parameters:
- DATAWIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata.
- ADDRESSWIDTH, 8, width of paddr/cmd_addr.
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESSWIDTH  transfer address.
- cmd_wdata  in  DATAWIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse, transfer finished.
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr captured, or timeout abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDRESSWIDTH  APB address.
- pwdata  out  DATAWIDTH  APB write data.
- prdata  in  DATAWIDTH  APB read data.
- pready  in  1  APB ready; tie 1 for zero-wait slaves such as apb_slave.
- pslverr  in  1  APB error; tie 0 if unused.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset state: while rst=1, state=IDLE and all outputs are 0 (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, wait counter). cmd_ready is also 0 while rst=1.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: register pwrite, paddr and pwdata (pwdata only when writing, else 0), set psel=1, penable=0, go to SETUP.
- SETUP:
  - Lasts exactly one cycle with cmd_ready=0.
  - Next edge: penable=1, go to ACCESS.
- ACCESS with pready=1:
  - Transfer completes at that edge.
  - Drive psel=0, penable=0, rsp_valid=1 for exactly one cycle.
  - rsp_err=pslverr.
  - rsp_rdata = prdata for reads, 0 for writes.
  - Go to IDLE.
- ACCESS with pready=0:
  - Hold psel=1, penable=1; paddr, pwdata and pwrite stay stable.
  - Increment the wait counter.
- Timeout (TIMEOUT>0): if pready=0 with wait counter = TIMEOUT-1, abort at that edge.
  - psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - ACCESS therefore never exceeds TIMEOUT cycles.
- Wait counter: width $clog2(TIMEOUT+1); cleared on entry to SETUP.
- Latency: command accepted at edge N gives:
  - psel high in cycle N+1;
  - penable high in cycle N+2;
  - with zero wait states, rsp_valid high in cycle N+3 and cmd_ready high again in N+3.
- Throughput: minimum 3 cycles per transfer. No back-to-back ACCESS→SETUP.
- paddr, pwdata and pwrite hold their last values in IDLE; they change only on command acceptance.
- rsp_rdata and rsp_err hold their values until the next completion. rsp_valid is not back-pressured.
- rst asserted mid-transfer: the transfer is dropped immediately (asynchronously), with no response pulse.
- cmd_valid while cmd_ready=0: ignored. The source must hold the command until it sees cmd_ready.

Decomposition:
- Package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - default DATAWIDTH/ADDRESSWIDTH localparams;
  - response-code constants (OKAY=0, ERR=1).
- The wait-state timer may be a sub-module apb_wait_timer (clear, enable, expired output).
- FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write then read, with apb_slave attached (pready=1, pslverr=0):
  - Write addr 0x26 data 0x68 → psel rises N+1, penable N+2, rsp_valid N+3 with rsp_err=0.
  - Read 0x26 → rsp_rdata=0x68.
- Second address: write 0x28←0x52, read 0x28 → rsp_rdata=0x52; a read of 0x26 still returns 0x68.
- Wait states: pready held low 3 ACCESS cycles, then high → penable high 4 cycles, signals stable throughout, single rsp_valid, rsp_err=0.
- Timeout: TIMEOUT=4, pready stuck 0 → ACCESS exactly 4 cycles, then psel=penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, and cmd_ready=1 in the following cycle.
- Slave error: pslverr=1 with pready=1 on a read → rsp_err=1, rsp_rdata=prdata.
- Reset mid-transfer: assert rst during ACCESS → all outputs 0 immediately, no rsp_valid. After release, a write of 0x26←0x11 completes normally.
